uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single `uart_tx` transmitter among `NUM_REQ` byte sources. It sits between the requesters and one `uart_tx` instance: it selects one pending requester, presents that requester's byte to the transmitter with `start`, and acknowledges the requester once the transmitter accepts the byte. It then holds off further grants until the frame has completed. There is no internal queue; each requester holds its byte until acknowledged.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one uart_tx among NUM_REQ byte sources, one frame per grant.
//             Build option UART_ARB_RR_EN: round-robin (defined) or fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int ID_W      = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [DATA_BITS-1:0]         tx_din,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [ID_W-1:0]              grant_id,
    output logic                         active
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                state_q,    state_d;
    logic [NUM_REQ-1:0]    req_ack_q,  req_ack_d;
    logic [DATA_BITS-1:0]  tx_din_q,   tx_din_d;
    logic                  tx_start_q, tx_start_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic                  active_q,   active_d;

    logic [ID_W-1:0]       win_id;
    logic [DATA_BITS-1:0]  win_data;
    logic                  grant;

    assign grant = (state_q == ST_IDLE) && !tx_busy && (|req);

`ifdef UART_ARB_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    // Lowest set index at or above the pointer wins; otherwise wrap to the lowest set index.
    always_comb begin
        win_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_id = ID_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) >= ptr_q)) win_id = ID_W'(i);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_id = ID_W'(i);
        end
    end
`endif

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) win_data = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ack_d  = '0;
        tx_din_d   = tx_din_q;
        tx_start_d = tx_start_q;
        grant_id_d = grant_id_q;
        active_d   = active_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    tx_din_d   = win_data;
                    grant_id_d = win_id;
                    tx_start_d = 1'b1;
                    active_d   = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end
            // start is held until uart_tx shows it took the byte on its baud tick
            ST_LAUNCH: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    req_ack_d  = NUM_REQ'(1) << grant_id_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_start_d = 1'b0;
                active_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            req_ack_q  <= '0;
            tx_din_q   <= '0;
            tx_start_q <= 1'b0;
            grant_id_q <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_ack_q  <= req_ack_d;
            tx_din_q   <= tx_din_d;
            tx_start_q <= tx_start_d;
            grant_id_q <= grant_id_d;
            active_q   <= active_d;
        end
    end

    assign req_ack  = req_ack_q;
    assign tx_din   = tx_din_q;
    assign tx_start = tx_start_q;
    assign grant_id = grant_id_q;
    assign active   = active_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed vector bench for uart_tx_arbiter; tx_busy stands in for uart_tx.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ack;
    logic [7:0]  tx_din;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        active;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .ID_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .req_ack  (req_ack),
        .tx_din   (tx_din),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [3:0]  req;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  ack;
        logic        start;
        logic [7:0]  din;
        logic [1:0]  id;
        logic        act;
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;

    task automatic add(input logic rstn, input logic [3:0] r, input logic [31:0] d,
                       input logic b, input logic [3:0] ack, input logic st,
                       input logic [7:0] din, input logic [1:0] id, input logic act);
        vecs[n_vec] = '{rstn, r, d, b, ack, st, din, id, act};
        n_vec++;
    endtask

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {ack,start,din,id,active}=%h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic [3:0] ack, input logic st,
                                         input logic [7:0] din, input logic [1:0] id,
                                         input logic act);
        return {ack, st, din, id, act};
    endfunction

    function automatic logic [15:0] outs();
        return {req_ack, tx_start, tx_din, grant_id, active};
    endfunction

    int w;
    logic [7:0] b;

    initial begin
        // Single request to 2, start held across a slow baud tick, then a request blocked by busy in IDLE.
        add(0, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 2'd0, 0);
        add(1, 4'b0100, 32'h00A50000, 0, 4'b0000, 1, 8'hA5, 2'd2, 1);
        add(1, 4'b0100, 32'h00A50000, 0, 4'b0000, 1, 8'hA5, 2'd2, 1);
        add(1, 4'b0100, 32'h00A50000, 1, 4'b0100, 0, 8'hA5, 2'd2, 1);
        add(1, 4'b0000, 32'h00A50000, 1, 4'b0000, 0, 8'hA5, 2'd2, 1);
        add(1, 4'b0000, 32'h00A50000, 0, 4'b0000, 0, 8'hA5, 2'd2, 0);
        add(1, 4'b0000, 32'h00A50000, 0, 4'b0000, 0, 8'hA5, 2'd2, 0);
        add(1, 4'b0001, 32'h000000EE, 1, 4'b0000, 0, 8'hA5, 2'd2, 0);
        add(1, 4'b0001, 32'h000000EE, 0, 4'b0000, 1, 8'hEE, 2'd0, 1);
        add(1, 4'b0001, 32'h000000EE, 1, 4'b0001, 0, 8'hEE, 2'd0, 1);
        add(1, 4'b0000, 32'h000000EE, 0, 4'b0000, 0, 8'hEE, 2'd0, 0);

        // All four requesting continuously, five frames.
        add(0, 4'b1111, 32'h43322110, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
        for (int k = 0; k < 5; k++) begin
`ifdef UART_ARB_RR_EN
            w = k % 4;
`else
            w = 0;
`endif
            b = 8'h10 + 8'h11 * 8'(w);
            add(1, 4'b1111, 32'h43322110, 0, 4'b0000,            1, b, 2'(w), 1);
            add(1, 4'b1111, 32'h43322110, 1, 4'b0001 << w,       0, b, 2'(w), 1);
            add(1, 4'b1111, 32'h43322110, 0, 4'b0000,            0, b, 2'(w), 0);
        end

        // Requester 1 withdraws and changes its byte during LAUNCH.
        add(0, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 2'd0, 0);
        add(1, 4'b0010, 32'h00003C00, 0, 4'b0000, 1, 8'h3C, 2'd1, 1);
        add(1, 4'b0000, 32'h0000FF00, 0, 4'b0000, 1, 8'h3C, 2'd1, 1);
        add(1, 4'b0000, 32'h0000FF00, 1, 4'b0010, 0, 8'h3C, 2'd1, 1);
        add(1, 4'b0000, 32'h0000FF00, 0, 4'b0000, 0, 8'h3C, 2'd1, 0);

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            reset_n  = vecs[i].rstn;
            req      = vecs[i].req;
            req_data = vecs[i].data;
            tx_busy  = vecs[i].busy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(),
                  pack(vecs[i].ack, vecs[i].start, vecs[i].din, vecs[i].id, vecs[i].act));
        end

        // Asynchronous reset in WAIT, then requester 3 re-arbitrated.
        @(negedge clk);
        reset_n = 1'b1; req = 4'b1000; req_data = 32'h77000000; tx_busy = 1'b0;
        @(posedge clk); #1;
        check("rst_grant3", outs(), pack(4'b0000, 1, 8'h77, 2'd3, 1));
        @(negedge clk); tx_busy = 1'b1;
        @(posedge clk); #1;
        check("rst_ack3", outs(), pack(4'b1000, 0, 8'h77, 2'd3, 1));
        @(negedge clk);
        @(posedge clk); #1;
        check("rst_wait", outs(), pack(4'b0000, 0, 8'h77, 2'd3, 1));
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("rst_immediate", outs(), pack(4'b0000, 0, 8'h00, 2'd0, 0));
        @(posedge clk); #1;
        check("rst_held", outs(), pack(4'b0000, 0, 8'h00, 2'd0, 0));
        @(negedge clk); reset_n = 1'b1; tx_busy = 1'b0;
        @(posedge clk); #1;
        check("rst_regrant3", outs(), pack(4'b0000, 1, 8'h77, 2'd3, 1));
        @(negedge clk); tx_busy = 1'b1; req = 4'b0000;
        @(posedge clk); #1;
        check("rst_reack3", outs(), pack(4'b1000, 0, 8'h77, 2'd3, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
